// File: rtl/pong_game_ctrl.sv
// Per-frame pong sequencer: detects end of active frame, then steps paddles, ball, scores and game state.
// Optional PONG_AI_EN: right paddle follows the ball instead of its buttons.
module pong_game_ctrl #(
    parameter int H_ACTIVE        = 480,
    parameter int V_ACTIVE        = 272,
    parameter int BALL_SIZE       = 8,
    parameter int PADDLE_W        = 8,
    parameter int PADDLE_H        = 48,
    parameter int PADDLE_X_OFFSET = 16,
    parameter int PADDLE_STEP     = 4,
    parameter int BALL_SPEED      = 2,
    parameter int SCORE_MAX       = 9,
    parameter int SERVE_FRAMES    = 60
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_data_enable,
    input  logic [8:0] i_col,
    input  logic [8:0] i_row,
    input  logic       i_btn_l_up,
    input  logic       i_btn_l_dn,
    input  logic       i_btn_r_up,
    input  logic       i_btn_r_dn,
    input  logic       i_start,
    output logic       o_frame_tick,
    output logic [1:0] o_state,
    output logic [8:0] o_ball_x,
    output logic [8:0] o_ball_y,
    output logic [8:0] o_paddle_l_y,
    output logic [8:0] o_paddle_r_y,
    output logic [3:0] o_score_l,
    output logic [3:0] o_score_r
);

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, GAME_OVER = 2'd3} state_t;

    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic signed [9:0] SPD    = 10'(BALL_SPEED);
    localparam logic signed [9:0] STEP   = 10'(PADDLE_STEP);
    localparam logic signed [9:0] CX     = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic signed [9:0] CY     = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic signed [9:0] Y_MAX  = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [9:0] X_MAX  = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [9:0] L_FACE = 10'(PADDLE_X_OFFSET + PADDLE_W);
    localparam logic signed [9:0] R_FACE = 10'(H_ACTIVE - PADDLE_X_OFFSET - PADDLE_W - BALL_SIZE);
    localparam logic signed [9:0] P_MAX  = 10'(V_ACTIVE - PADDLE_H);
    localparam logic [9:0]        BSZ    = 10'(BALL_SIZE);
    localparam logic [9:0]        PH     = 10'(PADDLE_H);
    localparam logic [8:0]        P_INIT = 9'((V_ACTIVE - PADDLE_H) / 2);

    state_t           state_q, state_d;
    logic             tick_q;
    logic [8:0]       bx_q, bx_d, by_q, by_d;
    logic             dx_q, dx_d, dy_q, dy_d;
    logic [8:0]       pl_q, pl_d, pr_q, pr_d;
    logic [3:0]       sl_q, sl_d, sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic signed [9:0] nx, ny;
    logic              l_hit, r_hit, r_up, r_dn;
    logic [8:0]        pl_n, pr_n;

    function automatic logic [8:0] move_pad(input logic [8:0] y, input logic up, input logic dn);
        logic signed [9:0] n;
        n = signed'({1'b0, y});
        if (up && !dn)      n = n - STEP;
        else if (dn && !up) n = n + STEP;
        if (n < 10'sd0)     n = 10'sd0;
        else if (n > P_MAX) n = P_MAX;
        return n[8:0];
    endfunction

    // Ball/paddle vertical overlap, using pre-move positions.
    function automatic logic overlap(input logic [8:0] by, input logic [8:0] py);
        return ({1'b0, by} + BSZ > {1'b0, py}) && ({1'b0, by} < {1'b0, py} + PH);
    endfunction

`ifdef PONG_AI_EN
    logic [9:0] ball_c, pad_c;
    logic       unused_btn_r;
    assign unused_btn_r = i_btn_r_up ^ i_btn_r_dn;
    assign ball_c = {1'b0, by_q} + BSZ / 10'd2;
    assign pad_c  = {1'b0, pr_q} + PH / 10'd2;
    assign r_up   = ball_c < pad_c;
    assign r_dn   = ball_c > pad_c;
`else
    assign r_up = i_btn_r_up;
    assign r_dn = i_btn_r_dn;
`endif

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        pl_d    = pl_q;
        pr_d    = pr_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;

        ny    = signed'({1'b0, by_q}) + (dy_q ? SPD : -SPD);
        nx    = signed'({1'b0, bx_q}) + (dx_q ? SPD : -SPD);
        l_hit = !dx_q && (nx <= L_FACE) && (signed'({1'b0, bx_q}) >= L_FACE) && overlap(by_q, pl_q);
        r_hit = dx_q && (nx >= R_FACE) && (signed'({1'b0, bx_q}) <= R_FACE) && overlap(by_q, pr_q);
        pl_n  = move_pad(pl_q, i_btn_l_up, i_btn_l_dn);
        pr_n  = move_pad(pr_q, r_up, r_dn);

        if (tick_q) begin
            unique case (state_q)
                IDLE, GAME_OVER: begin
                    if (i_start) begin
                        state_d = SERVE;
                        sl_d    = 4'd0;
                        sr_d    = 4'd0;
                    end
                end
                SERVE: begin
                    pl_d = pl_n;
                    pr_d = pr_n;
                    bx_d = CX[8:0];
                    by_d = CY[8:0];
                    if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PLAY: begin
                    pl_d = pl_n;
                    pr_d = pr_n;
                    if (ny <= 10'sd0) begin
                        by_d = 9'd0;
                        dy_d = 1'b1;
                    end else if (ny >= Y_MAX) begin
                        by_d = Y_MAX[8:0];
                        dy_d = 1'b0;
                    end else begin
                        by_d = ny[8:0];
                    end
                    if (l_hit) begin
                        bx_d = L_FACE[8:0];
                        dx_d = 1'b1;
                    end else if (r_hit) begin
                        bx_d = R_FACE[8:0];
                        dx_d = 1'b0;
                    end else if (nx <= 10'sd0) begin
                        sr_d    = sr_q + 4'd1;
                        bx_d    = CX[8:0];
                        by_d    = CY[8:0];
                        dx_d    = 1'b0;
                        state_d = (sr_q + 4'd1 == 4'(SCORE_MAX)) ? GAME_OVER : SERVE;
                    end else if (nx >= X_MAX) begin
                        sl_d    = sl_q + 4'd1;
                        bx_d    = CX[8:0];
                        by_d    = CY[8:0];
                        dx_d    = 1'b1;
                        state_d = (sl_q + 4'd1 == 4'(SCORE_MAX)) ? GAME_OVER : SERVE;
                    end else begin
                        bx_d = nx[8:0];
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            tick_q  <= 1'b0;
            bx_q    <= CX[8:0];
            by_q    <= CY[8:0];
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            pl_q    <= P_INIT;
            pr_q    <= P_INIT;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= i_data_enable && (i_col == 9'(H_ACTIVE - 1)) && (i_row == 9'(V_ACTIVE - 1));
            bx_q    <= bx_d;
            by_q    <= by_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_frame_tick = tick_q;
    assign o_state      = state_q;
    assign o_ball_x     = bx_q;
    assign o_ball_y     = by_q;
    assign o_paddle_l_y = pl_q;
    assign o_paddle_r_y = pr_q;
    assign o_score_l    = sl_q;
    assign o_score_r    = sr_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: integer game model checked every cycle, plus directed literal checks.
module tb_pong_game_ctrl;
    localparam int SF = 2;

    logic       i_clk = 1'b0, i_rst_n = 1'b0, i_data_enable = 1'b0;
    logic [8:0] i_col = '0, i_row = '0;
    logic       i_btn_l_up = 0, i_btn_l_dn = 0, i_btn_r_up = 0, i_btn_r_dn = 0, i_start = 0;
    logic       o_frame_tick;
    logic [1:0] o_state;
    logic [8:0] o_ball_x, o_ball_y, o_paddle_l_y, o_paddle_r_y;
    logic [3:0] o_score_l, o_score_r;

    pong_game_ctrl #(.SERVE_FRAMES(SF)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_enable(i_data_enable),
        .i_col(i_col), .i_row(i_row),
        .i_btn_l_up(i_btn_l_up), .i_btn_l_dn(i_btn_l_dn),
        .i_btn_r_up(i_btn_r_up), .i_btn_r_dn(i_btn_r_dn), .i_start(i_start),
        .o_frame_tick(o_frame_tick), .o_state(o_state),
        .o_ball_x(o_ball_x), .o_ball_y(o_ball_y),
        .o_paddle_l_y(o_paddle_l_y), .o_paddle_r_y(o_paddle_r_y),
        .o_score_l(o_score_l), .o_score_r(o_score_r)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Game model in plain integers: states 0 idle, 1 serve, 2 play, 3 game over.
    int m_state, m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_cnt;
    bit m_dx, m_dy, m_tick;

    function automatic int pad(input int y, input bit u, input bit d);
        if (u && !d) y -= 4;
        else if (d && !u) y += 4;
        if (y < 0) y = 0;
        if (y > 224) y = 224;
        return y;
    endfunction

    task automatic model_reset();
        m_state = 0; m_bx = 236; m_by = 132; m_pl = 112; m_pr = 112;
        m_sl = 0; m_sr = 0; m_cnt = 0; m_dx = 1; m_dy = 1; m_tick = 0;
    endtask

    task automatic model_step(input bit lu, ld, ru, rd, st);
        int ox, oy, opl, opr, nx, ny;
        bit rue, rde, lhit, rhit;
`ifdef PONG_AI_EN
        rue = (m_by + 4) < (m_pr + 24);
        rde = (m_by + 4) > (m_pr + 24);
`else
        rue = ru; rde = rd;
`endif
        ox = m_bx; oy = m_by; opl = m_pl; opr = m_pr;
        case (m_state)
            0, 3: if (st) begin m_state = 1; m_sl = 0; m_sr = 0; end
            1: begin
                m_pl = pad(m_pl, lu, ld); m_pr = pad(m_pr, rue, rde);
                m_bx = 236; m_by = 132;
                if (m_cnt == SF - 1) begin m_cnt = 0; m_state = 2; end
                else m_cnt++;
            end
            default: begin
                m_pl = pad(m_pl, lu, ld); m_pr = pad(m_pr, rue, rde);
                ny = oy + (m_dy ? 2 : -2);
                if (ny <= 0) begin m_by = 0; m_dy = 1; end
                else if (ny >= 264) begin m_by = 264; m_dy = 0; end
                else m_by = ny;
                nx = ox + (m_dx ? 2 : -2);
                lhit = !m_dx && nx <= 24 && ox >= 24 && oy + 8 > opl && oy < opl + 48;
                rhit = m_dx && nx >= 448 && ox <= 448 && oy + 8 > opr && oy < opr + 48;
                if (lhit) begin m_bx = 24; m_dx = 1; end
                else if (rhit) begin m_bx = 448; m_dx = 0; end
                else if (nx <= 0) begin
                    m_sr++; m_bx = 236; m_by = 132; m_dx = 0;
                    m_state = (m_sr == 9) ? 3 : 1;
                end else if (nx >= 472) begin
                    m_sl++; m_bx = 236; m_by = 132; m_dx = 1;
                    m_state = (m_sl == 9) ? 3 : 1;
                end else m_bx = nx;
            end
        endcase
    endtask

    always @(posedge i_clk) begin
        if (!i_rst_n) model_reset();
        else begin
            if (m_tick) model_step(i_btn_l_up, i_btn_l_dn, i_btn_r_up, i_btn_r_dn, i_start);
            m_tick = i_data_enable && i_col == 9'd479 && i_row == 9'd271;
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("tick", int'(o_frame_tick), int'(m_tick));
            chk("state", int'(o_state), m_state);
            chk("ball_x", int'(o_ball_x), m_bx);
            chk("ball_y", int'(o_ball_y), m_by);
            chk("pad_l", int'(o_paddle_l_y), m_pl);
            chk("pad_r", int'(o_paddle_r_y), m_pr);
            chk("score_l", int'(o_score_l), m_sl);
            chk("score_r", int'(o_score_r), m_sr);
        end
    end

    // One frame end: near-miss pixels, the last pixel, then button/start noise between ticks.
    task automatic frame(input bit lu, ld, ru, rd, st);
        i_btn_l_up = lu; i_btn_l_dn = ld; i_btn_r_up = ru; i_btn_r_dn = rd; i_start = st;
        i_data_enable = 1; i_col = 9'd479; i_row = 9'd270; @(negedge i_clk);
        i_col = 9'd478; i_row = 9'd271; @(negedge i_clk);
        i_col = 9'd479; @(negedge i_clk);
        i_data_enable = 0; @(negedge i_clk);
        i_btn_l_up = 1; i_btn_r_dn = 1; i_start = 1; i_btn_l_dn = 0; i_btn_r_up = 0;
        @(negedge i_clk);
        i_btn_l_up = 0; i_btn_r_dn = 0; i_start = 0; i_col = 9'd0; i_row = 9'd0;
    endtask

    task automatic steer(input int p, input int goal, output bit u, output bit d);
        u = p > goal; d = p < goal;
    endtask

    task automatic track(input int p, input int by, output bit u, output bit d);
        u = (by + 4) < (p + 24); d = (by + 4) > (p + 24);
    endtask

    // mode 0: right tracks, left dodges, until right reaches target; mode 1: mirrored, until game over.
    task automatic play_phase(input int mode, input int target);
        bit lu, ld, ru, rd, near, done;
        int goal;
        goal = -1; done = 0;
        for (int n = 0; n < 2500 && !done; n++) begin
            if (mode == 0) begin
                track(m_pr, m_by, ru, rd);
                near = m_state == 2 && !m_dx && m_bx <= 84;
                if (near && goal < 0) goal = (m_by < 132) ? 224 : 0;
                if (!near) goal = -1;
                steer(m_pl, near ? goal : 112, lu, ld);
            end else begin
                track(m_pl, m_by, lu, ld);
                near = m_state == 2 && m_dx && m_bx >= 388;
                if (near && goal < 0) goal = (m_by < 132) ? 224 : 0;
                if (!near) goal = -1;
                steer(m_pr, near ? goal : 112, ru, rd);
            end
            frame(lu, ld, ru, rd, 0);
            done = (mode == 0) ? (m_sr >= target || m_state == 3) : (m_state == 3);
        end
        chk("phase_done", int'(done), 1);
    endtask

    initial begin
        int keep_pl;
        repeat (3) @(negedge i_clk);
        chk_en = 1;
        chk("rst_state", int'(o_state), 0);
        chk("rst_ball", int'({o_ball_x, o_ball_y}), (236 << 9) | 132);
        chk("rst_pads", int'({o_paddle_l_y, o_paddle_r_y}), (112 << 9) | 112);
        chk("rst_tick", int'(o_frame_tick), 0);
        i_rst_n = 1;
        @(negedge i_clk);

        frame(0, 0, 0, 0, 0);
        chk("idle_hold", int'(o_state), 0);
        frame(0, 0, 0, 0, 1);
        chk("to_serve", int'(o_state), 1);
        chk("serve_scores", int'({o_score_l, o_score_r}), 0);
        frame(0, 0, 0, 0, 0);
        chk("serve2", int'(o_state), 1);
        frame(0, 0, 0, 0, 0);
        chk("to_play", int'(o_state), 2);
        frame(0, 0, 0, 0, 0);
        chk("first_move_x", int'(o_ball_x), 238);
        chk("first_move_y", int'(o_ball_y), 134);
        chk("ai_hold", int'(o_paddle_r_y), 112);
        frame(1, 0, 0, 0, 0);
        chk("pad_l_up", int'(o_paddle_l_y), 108);
`ifdef PONG_AI_EN
        chk("ai_down", int'(o_paddle_r_y), 116);
`else
        chk("pad_r_idle", int'(o_paddle_r_y), 112);
`endif
        repeat (29) frame(1, 0, 0, 0, 0);
        chk("pad_l_top", int'(o_paddle_l_y), 0);
        repeat (2) frame(1, 1, 0, 0, 0);
        chk("pad_l_both", int'(o_paddle_l_y), 0);
        repeat (60) frame(0, 1, 0, 0, 0);
        chk("pad_l_bottom", int'(o_paddle_l_y), 224);

`ifdef PONG_AI_EN
        play_phase(0, 9);
        chk("go_score_r", int'(o_score_r), 9);
`else
        play_phase(0, 5);
        chk("phaseA_score_r", int'(o_score_r), 5);
        play_phase(1, 0);
        chk("go_score_l", int'(o_score_l), 9);
`endif
        chk("game_over", int'(o_state), 3);
        keep_pl = m_pl;
        repeat (2) frame(1, 0, 0, 1, 0);
        chk("go_frozen_ball", int'({o_ball_x, o_ball_y}), (236 << 9) | 132);
        chk("go_frozen_pad", int'(o_paddle_l_y), keep_pl);
        chk("go_still", int'(o_state), 3);
        frame(0, 0, 0, 0, 1);
        chk("restart", int'(o_state), 1);
        chk("restart_scores", int'({o_score_l, o_score_r}), 0);
        repeat (SF + 3) frame(0, 1, 1, 0, 0);
        chk("mid_play", int'(o_state), 2);

        i_rst_n = 0; @(negedge i_clk);
        i_rst_n = 1;
        chk("mrst_state", int'(o_state), 0);
        chk("mrst_ball", int'({o_ball_x, o_ball_y}), (236 << 9) | 132);
        chk("mrst_pads", int'({o_paddle_l_y, o_paddle_r_y}), (112 << 9) | 112);
        chk("mrst_scores", int'({o_score_l, o_score_r}), 0);
        frame(0, 0, 0, 0, 0);
        chk("mrst_idle", int'(o_state), 0);
        repeat (2) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
